regfile_scrub_param: RTL and testbench

//  Parametrised 2-read/1-write general-purpose register file for the datapath; next generation of the fixed 32x32 file.

---
 rtl/regfile_scrub_param_if.sv | 26 ++
 rtl/regfile_scrub_param.sv | 109 ++++++++++
 tb/tb_regfile_scrub_param.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/regfile_scrub_param_if.sv
// Register-file access bus: write port, two read addresses, and registered read/status returns.
// The decode/writeback side uses the master modport; the register file uses the slave modport.
interface regfile_scrub_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              RegWr;
  logic [ADDR_W-1:0] Writad;
  logic [DATA_W-1:0] Writedata;
  logic [ADDR_W-1:0] Readad1;
  logic [ADDR_W-1:0] Readad2;
  logic [DATA_W-1:0] Read1;
  logic [DATA_W-1:0] Read2;
  logic              Ready;
  logic              WrDrop;

  modport master (
    output RegWr, Writad, Writedata, Readad1, Readad2,
    input  Read1, Read2, Ready, WrDrop
  );

  modport slave (
    input  RegWr, Writad, Writedata, Readad1, Readad2,
    output Read1, Read2, Ready, WrDrop
  );
endinterface

// File: rtl/regfile_scrub_param.sv
// 2-read/1-write register file with registered reads, optional hardwired-zero entry and post-reset scrub.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile_scrub_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic                  CLK,
  input logic                  RESET,
  regfile_scrub_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {SCRUB, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] scrub_cnt_q, scrub_cnt_d;
  logic              ready_q, ready_d;
  logic              wr_drop_q, wr_drop_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              user_wr;

  assign user_wr = bus.RegWr & ready_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= SCRUB;
      scrub_cnt_q <= '0;
      ready_q     <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
      ready_q     <= ready_d;
      wr_drop_q   <= wr_drop_d;
    end
  end

  // The scrub owns the single write port until Ready, so user writes are dropped meanwhile.
  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    ready_d     = ready_q;
    wr_drop_d   = bus.RegWr & ~ready_q;
    mem_we      = 1'b0;
    mem_waddr   = bus.Writad;
    mem_wdata   = bus.Writedata;
    case (state_q)
      SCRUB: begin
        mem_we      = 1'b1;
        mem_waddr   = scrub_cnt_q;
        mem_wdata   = '0;
        scrub_cnt_d = scrub_cnt_q + 1'b1;
        if (scrub_cnt_q == {ADDR_W{1'b1}}) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        mem_we = user_wr && !((ZERO_REG != 0) && (bus.Writad == '0));
      end
      default: state_d = SCRUB;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  logic [ADDR_W-1:0] raddr [2];
  assign raddr[0] = bus.Readad1;
  assign raddr[1] = bus.Readad2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [DATA_W-1:0] rd_d, rd_q;

    // Zero-entry and not-ready gating are applied last so they override the bypass.
    always_comb begin
      rd_d = mem[raddr[gi]];
`ifdef REGFILE_BYPASS_EN
      if (user_wr && (raddr[gi] == bus.Writad)) begin
        rd_d = bus.Writedata;
      end
`endif
      if (!ready_q || ((ZERO_REG != 0) && (raddr[gi] == '0))) begin
        rd_d = '0;
      end
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end
  end

  assign bus.Read1  = g_rd[0].rd_q;
  assign bus.Read2  = g_rd[1].rd_q;
  assign bus.Ready  = ready_q;
  assign bus.WrDrop = wr_drop_q;
endmodule

// File: tb/tb_regfile_scrub_param.sv
// Directed bench: one DUT with the hardwired zero entry, one without, driven with identical stimulus.
// Expected values are hand-computed; bypass-dependent expectations follow REGFILE_BYPASS_EN.
module tb_regfile_scrub_param;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  regfile_scrub_param_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  regfile_scrub_param_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

  regfile_scrub_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut0 (
    .CLK(clk), .RESET(rst), .bus(if0.slave)
  );
  regfile_scrub_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut1 (
    .CLK(clk), .RESET(rst), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    if0.RegWr = we; if0.Writad = wa; if0.Writedata = wd; if0.Readad1 = r1; if0.Readad2 = r2;
    if1.RegWr = we; if1.Writad = wa; if1.Writedata = wd; if1.Readad1 = r1; if1.Readad2 = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] byp_exp;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    #2;
    check("reset Read1", if0.Read1, 32'h0);
    check("reset Read2", if0.Read2, 32'h0);
    check("reset Ready", {31'h0, if0.Ready}, 32'h0);
    check("reset WrDrop", {31'h0, if0.WrDrop}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T1: Ready rises exactly on edge 32, then every entry reads 0
    for (int n = 1; n <= 32; n++) begin
      tick();
      check($sformatf("T1 Ready edge %0d", n), {31'h0, if0.Ready}, (n == 32) ? 32'h1 : 32'h0);
    end
    check("T1 Ready dut1", {31'h0, if1.Ready}, 32'h1);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      tick();
      check($sformatf("T1 scrub rd1 %0d", i), if1.Read1, 32'h0);
      check($sformatf("T1 scrub rd2 %0d", 31 - i), if1.Read2, 32'h0);
    end

    // T2: basic writes and dual reads
    drive(1'b1, 5'd11, 32'hDEADBEEF, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd12, 32'h12345678, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd11, 5'd12);
    tick();
    check("T2 Read1", if0.Read1, 32'hDEADBEEF);
    check("T2 Read2", if0.Read2, 32'h12345678);

    // T3: hardwired zero entry vs ordinary entry 0
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd11, 5'd12);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    check("T3 zero WrDrop", {31'h0, if0.WrDrop}, 32'h0);
    check("T3 zero Read1", if0.Read1, 32'h0);
    check("T3 zero Read2", if0.Read2, 32'h0);
    check("T3 plain Read1", if1.Read1, 32'hFFFFFFFF);
    check("T3 plain Read2", if1.Read2, 32'hFFFFFFFF);

    // T5: same-cycle write/read of one address
    drive(1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd7, 32'h42, 5'd7, 5'd7);
    tick();
`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'h42;
`else
    byp_exp = 32'h1;
`endif
    check("T5 same-cycle Read1", if0.Read1, byp_exp);
    check("T5 same-cycle Read2", if0.Read2, byp_exp);
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    tick();
    check("T5 next Read1", if0.Read1, 32'h42);
    check("T5 next Read2", if0.Read2, 32'h42);

    // T6: async reset mid-operation
    drive(1'b1, 5'd3, 32'hCAFE, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd5, 32'h55, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
    tick();
    check("T6 pre Read1", if0.Read1, 32'hCAFE);
    check("T6 pre Read2", if0.Read2, 32'h55);
    #3;
    rst = 1'b1;
    #1;
    check("T6 async Read1", if0.Read1, 32'h0);
    check("T6 async Read2", if0.Read2, 32'h0);
    check("T6 async Ready", {31'h0, if0.Ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Rescrub with T4 dropped writes at scrub edge 3 and at the final scrub edge
    for (int n = 1; n <= 32; n++) begin
      if (n == 3) drive(1'b1, 5'd5, 32'hA5A5A5A5, 5'd3, 5'd5);
      else if (n == 32) drive(1'b1, 5'd6, 32'h77, 5'd3, 5'd5);
      else drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
      tick();
      check($sformatf("T6 Ready edge %0d", n), {31'h0, if0.Ready}, (n == 32) ? 32'h1 : 32'h0);
      if (n == 3) check("T4 WrDrop pulse", {31'h0, if0.WrDrop}, 32'h1);
      if (n == 4) check("T4 WrDrop clear", {31'h0, if0.WrDrop}, 32'h0);
      if (n == 32) check("T4 WrDrop final edge", {31'h0, if0.WrDrop}, 32'h1);
    end
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
    tick();
    check("T4 WrDrop after", {31'h0, if0.WrDrop}, 32'h0);
    check("T6 reg3 scrubbed", if0.Read1, 32'h0);
    check("T4 reg5 dropped", if0.Read2, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd6);
    tick();
    check("T4 reg6 dropped", if0.Read1, 32'h0);
    check("T4 reg6 dropped dut1", if1.Read2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
